slc3_fetch_unit: RTL and testbench

- Parametrised instruction-fetch engine for the SLC-3 core. Replaces the hard-wired PC/MAR/MDR/IR fetch path.
- Generalised in data/address width, memory read latency and reset vector.
- Adds a PC redirect input, a memory wait-state counter and a run/pause/single-step control FSM.
- Sits between the `control` FSM and the memory interface. Drives `mem_addr`, `mem_mem_ena` and `mem_wr_ena`, and presents `ir_o` to decode.

---
 rtl/slc3_pkg.sv | 22 ++
 rtl/load_reg_arn.sv | 27 ++
 rtl/slc3_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_slc3_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slc3_pkg                                                             |
// | Shared types and default widths for the SLC-3 fetch path.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package slc3_pkg;

  localparam int SLC3_DATA_W = 16;
  localparam int SLC3_ADDR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAR,
    S_WAIT,
    S_MDR,
    S_IR,
    S_PAUSE
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/load_reg_arn.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_reg_arn                                                         |
// | Load-enabled register with asynchronous active-low reset.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module load_reg_arn #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/slc3_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | slc3_fetch_unit                                                      |
// | Parametrised PC/MAR/MDR/IR instruction fetch engine with redirect,   |
// | memory wait-state counter and run/pause control.                     |
// | Option macro: SLC3_FETCH_SINGLE_STEP_EN (pause after each fetch).    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module slc3_fetch_unit
  import slc3_pkg::*;
#(
  parameter int                DATA_W      = SLC3_DATA_W,
  parameter int                ADDR_W      = SLC3_ADDR_W,
  parameter int                MEM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run_i,
  input  logic              continue_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_mem_ena,
  output logic              mem_wr_ena,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] ir_o,
  output logic              ir_valid_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] hex_display_debug
);

  localparam int                 C_CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(MEM_LATENCY - 1);

  fetch_state_t        r_state;
  fetch_state_t        w_state_nxt;
  logic [C_CNT_W-1:0]  r_wait_cnt;
  logic                r_cont_prev;
  logic                r_ir_valid;
  logic                w_cont_rise;
  logic                w_pc_load;
  logic                w_mar_load;
  logic                w_mdr_load;
  logic                w_ir_load;
  logic [ADDR_W-1:0]   w_pc_d;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   r_mar;
  logic [DATA_W-1:0]   r_mdr;
  logic [DATA_W-1:0]   r_ir;

  assign w_cont_rise = continue_i & ~r_cont_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_cont_prev <= 1'b0;
      r_ir_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cont_prev <= continue_i;
      r_ir_valid  <= w_ir_load;
      if (w_mar_load) begin
        r_wait_cnt <= C_CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - C_CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mar_load  = 1'b0;
    w_mdr_load  = 1'b0;
    w_ir_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run_i) w_state_nxt = S_MAR;
      end
      S_MAR: begin
        w_mar_load  = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_wait_cnt == '0) w_state_nxt = S_MDR;
      end
      S_MDR: begin
        w_mdr_load  = 1'b1;
        w_state_nxt = S_IR;
      end
      S_IR: begin
        w_ir_load = 1'b1;
`ifdef SLC3_FETCH_SINGLE_STEP_EN
        w_state_nxt = S_PAUSE;
`else
        w_state_nxt = run_i ? S_MAR : S_IDLE;
`endif
      end
      S_PAUSE: begin
        // Dropping run wins over a simultaneous continue edge
        if (!run_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_cont_rise) begin
          w_state_nxt = S_MAR;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A redirect replaces the increment; the in-flight MAR value is untouched
  assign w_pc_load = redirect_i | w_mar_load;
  assign w_pc_d    = redirect_i ? redirect_pc_i : (r_pc + ADDR_W'(1));

  load_reg_arn #(.DATA_WIDTH(ADDR_W), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk(clk), .reset(reset), .load(w_pc_load), .d(w_pc_d), .q(r_pc)
  );

  load_reg_arn #(.DATA_WIDTH(ADDR_W)) u_mar_reg (
    .clk(clk), .reset(reset), .load(w_mar_load), .d(r_pc), .q(r_mar)
  );

  load_reg_arn #(.DATA_WIDTH(DATA_W)) u_mdr_reg (
    .clk(clk), .reset(reset), .load(w_mdr_load), .d(mem_rdata), .q(r_mdr)
  );

  load_reg_arn #(.DATA_WIDTH(DATA_W)) u_ir_reg (
    .clk(clk), .reset(reset), .load(w_ir_load), .d(r_mdr), .q(r_ir)
  );

  assign mem_addr          = r_mar;
  assign mem_mem_ena       = (r_state == S_WAIT);
  assign mem_wr_ena        = 1'b0;
  assign pc_o              = r_pc;
  assign ir_o              = r_ir;
  assign ir_valid_o        = r_ir_valid;
  assign busy_o            = (r_state != S_IDLE) && (r_state != S_PAUSE);
  assign hex_display_debug = r_ir;

endmodule
`default_nettype wire

// File: tb/tb_slc3_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_slc3_fetch_unit                                                   |
// | Three fetch units (latency 1/3/4) on shared stimulus, checked        |
// | against a fetch-timeline reference model, vectors and sequences.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_slc3_fetch_unit;

  localparam int NI = 3;
`ifdef SLC3_FETCH_SINGLE_STEP_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 4;
  endfunction

  function automatic logic [15:0] rpc_of(input int g);
    return (g == 0) ? 16'h0000 : (g == 1) ? 16'h0100 : 16'hFFFF;
  endfunction

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0001) return 16'h5678;
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_i = 1'b0;
  logic        continue_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [15:0] redirect_pc_i = '0;

  logic [15:0] mem_rdata [NI] = '{default: '0};
  logic [15:0] mem_addr  [NI];
  logic [15:0] pc_o      [NI];
  logic [15:0] ir_o      [NI];
  logic [15:0] hex       [NI];
  logic        ena       [NI];
  logic        wr        [NI];
  logic        irv       [NI];
  logic        busy      [NI];
  int          rd_cnt    [NI] = '{default: 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    slc3_fetch_unit #(
      .DATA_W(16), .ADDR_W(16), .MEM_LATENCY(lat_of(g)), .RESET_PC(rpc_of(g))
    ) u_dut (
      .clk(clk), .reset(reset), .run_i(run_i), .continue_i(continue_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .mem_rdata(mem_rdata[g]), .mem_addr(mem_addr[g]), .mem_mem_ena(ena[g]),
      .mem_wr_ena(wr[g]), .pc_o(pc_o[g]), .ir_o(ir_o[g]), .ir_valid_o(irv[g]),
      .busy_o(busy[g]), .hex_display_debug(hex[g])
    );
  end

  // Memory: data becomes valid only after enable has been held for the latency
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (ena[g]) begin
        rd_cnt[g] <= rd_cnt[g] + 1;
        if (rd_cnt[g] + 1 == lat_of(g)) mem_rdata[g] <= mem_f(mem_addr[g]);
        else if (rd_cnt[g] == 0) mem_rdata[g] <= 16'hDEAD;
      end else begin
        rd_cnt[g] <= 0;
      end
    end
  end

  // Reference: m_k = cycles since fetch start, -1 idle, -2 paused
  int          m_k    [NI];
  logic [15:0] m_pc   [NI];
  logic [15:0] m_addr [NI];
  logic [15:0] m_ir   [NI];
  logic        m_v    [NI];
  logic        m_prev;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int g, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got %h expected %h", name, g, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < NI; g++) begin
      m_k[g] = -1; m_pc[g] = rpc_of(g); m_addr[g] = '0; m_ir[g] = '0; m_v[g] = 1'b0;
    end
    m_prev = 1'b0;
  endtask

  task automatic model_step();
    int          nk;
    logic [15:0] npc;
    if (!reset) begin
      model_reset();
    end else begin
      for (int g = 0; g < NI; g++) begin
        nk = m_k[g];
        npc = m_pc[g];
        m_v[g] = 1'b0;
        if (m_k[g] == 0) begin
          m_addr[g] = m_pc[g];
          npc = m_pc[g] + 16'd1;
        end
        if (redirect_i) npc = redirect_pc_i;
        if (m_k[g] == -1) begin
          nk = run_i ? 0 : -1;
        end else if (m_k[g] == -2) begin
          nk = !run_i ? -1 : (continue_i && !m_prev) ? 0 : -2;
        end else if (m_k[g] == lat_of(g) + 2) begin
          m_ir[g] = mem_f(m_addr[g]);
          m_v[g] = 1'b1;
          nk = SS ? -2 : (run_i ? 0 : -1);
        end else begin
          nk = m_k[g] + 1;
        end
        m_k[g] = nk;
        m_pc[g] = npc;
      end
      m_prev = continue_i;
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < NI; g++) begin
      chk("pc", g, pc_o[g], m_pc[g]);
      chk("mem_addr", g, mem_addr[g], m_addr[g]);
      chk("ir", g, ir_o[g], m_ir[g]);
      chk("hex", g, hex[g], m_ir[g]);
      chk("ir_valid", g, 16'(irv[g]), 16'(m_v[g]));
      chk("mem_ena", g, 16'(ena[g]), 16'((m_k[g] >= 1) && (m_k[g] <= lat_of(g))));
      chk("busy", g, 16'(busy[g]), 16'(m_k[g] >= 0));
      chk("wr_ena", g, 16'(wr[g]), 16'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    run_i = 1'b0; continue_i = 1'b0; redirect_i = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  typedef struct {
    logic        run;
    logic [15:0] pc;
    logic [15:0] addr;
    logic [15:0] ir;
    logic        ena;
    logic        busy;
    logic        v;
  } vec_t;

  vec_t tbl [6];
  int   first_valid [NI];
  int   ena_cnt     [NI];
  int   pulses;

  initial begin
    // Straight fetch on the latency-1 unit: run, MAR, WAIT, MDR, IR, loaded
    tbl[0] = '{run: 1'b0, pc: 16'h0000, addr: 16'h0000, ir: 16'h0000, ena: 1'b0, busy: 1'b0, v: 1'b0};
    tbl[1] = '{run: 1'b1, pc: 16'h0000, addr: 16'h0000, ir: 16'h0000, ena: 1'b0, busy: 1'b1, v: 1'b0};
    tbl[2] = '{run: 1'b1, pc: 16'h0001, addr: 16'h0000, ir: 16'h0000, ena: 1'b1, busy: 1'b1, v: 1'b0};
    tbl[3] = '{run: 1'b1, pc: 16'h0001, addr: 16'h0000, ir: 16'h0000, ena: 1'b0, busy: 1'b1, v: 1'b0};
    tbl[4] = '{run: 1'b1, pc: 16'h0001, addr: 16'h0000, ir: 16'h0000, ena: 1'b0, busy: 1'b1, v: 1'b0};
    tbl[5] = '{run: 1'b1, pc: 16'h0001, addr: 16'h0000, ir: 16'h1234, ena: 1'b0, busy: !SS, v: 1'b1};

    model_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      run_i = tbl[i].run;
      tick();
      chk("tbl_pc", i, pc_o[0], tbl[i].pc);
      chk("tbl_addr", i, mem_addr[0], tbl[i].addr);
      chk("tbl_ir", i, ir_o[0], tbl[i].ir);
      chk("tbl_ena", i, 16'(ena[0]), 16'(tbl[i].ena));
      chk("tbl_busy", i, 16'(busy[0]), 16'(tbl[i].busy));
      chk("tbl_valid", i, 16'(irv[0]), 16'(tbl[i].v));
    end
`ifndef SLC3_FETCH_SINGLE_STEP_EN
    tick();
    chk("fetch2_pc", 0, pc_o[0], 16'h0002);
    chk("fetch2_addr", 0, mem_addr[0], 16'h0001);
    tick(); tick(); tick();
    chk("fetch2_ir", 0, ir_o[0], 16'h5678);
    chk("fetch2_valid", 0, 16'(irv[0]), 16'd1);
`else
    tick(); tick();
    chk("pause_busy", 0, 16'(busy[0]), 16'd0);
    chk("pause_ir", 0, ir_o[0], 16'h1234);
    pulses = 0;
    continue_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (irv[0]) pulses++;
    end
    continue_i = 1'b0;
    chk("step_pulses", 0, 16'(pulses), 16'd1);
    chk("step_ir", 0, ir_o[0], 16'h5678);
    run_i = 1'b0;
    tick();
    chk("pause_to_idle_busy", 0, 16'(busy[0]), 16'd0);
    tick();
    chk("idle_stays", 0, 16'(busy[0]), 16'd0);
`endif

    // Latency sweep and PC wrap across all three units
    do_reset();
    for (int g = 0; g < NI; g++) begin
      first_valid[g] = 0;
      ena_cnt[g] = 0;
    end
    run_i = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      for (int g = 0; g < NI; g++) begin
        if (first_valid[g] == 0) begin
          if (ena[g]) ena_cnt[g]++;
          if (irv[g]) first_valid[g] = cyc;
        end
      end
      if (cyc == 2) begin
        chk("wrap_addr", 2, mem_addr[2], 16'hFFFF);
        chk("wrap_pc", 2, pc_o[2], 16'h0000);
      end
`ifndef SLC3_FETCH_SINGLE_STEP_EN
      if (cyc == 9) chk("wrap_addr2", 2, mem_addr[2], 16'h0000);
`endif
    end
    for (int g = 0; g < NI; g++) begin
      chk("ena_cycles", g, 16'(ena_cnt[g]), 16'(lat_of(g)));
      chk("first_valid", g, 16'(first_valid[g]), 16'(lat_of(g) + 4));
    end

    // Asynchronous reset in the middle of a latency-3 wait
    do_reset();
    run_i = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_ena", 1, 16'(ena[1]), 16'd1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_busy", 1, 16'(busy[1]), 16'd0);
    chk("arst_pc", 1, pc_o[1], 16'h0100);
    chk("arst_ena", 1, 16'(ena[1]), 16'd0);
    chk("arst_addr", 1, mem_addr[1], 16'h0000);
    chk("arst_ir", 1, ir_o[1], 16'h0000);
    check_all();
    tick();
    reset = 1'b1;

    // Redirect during the wait of the fetch at address 0
    do_reset();
    run_i = 1'b1;
    tick(); tick();
    redirect_i = 1'b1;
    redirect_pc_i = 16'h3000;
    tick();
    redirect_i = 1'b0;
    chk("redir_pc", 0, pc_o[0], 16'h3000);
    tick(); tick();
    chk("redir_ir", 0, ir_o[0], 16'h1234);
    chk("redir_valid", 0, 16'(irv[0]), 16'd1);
`ifdef SLC3_FETCH_SINGLE_STEP_EN
    continue_i = 1'b1;
    tick();
`endif
    tick();
    continue_i = 1'b0;
    chk("redir_addr", 0, mem_addr[0], 16'h3000);
    chk("redir_pc_next", 0, pc_o[0], 16'h3001);

    // Random traffic against the reference model
    for (int c = 0; c < 1500; c++) begin
      run_i = ($urandom_range(0, 15) != 0);
      continue_i = ($urandom_range(0, 3) == 0);
      redirect_i = ($urandom_range(0, 19) == 0);
      redirect_pc_i = 16'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        model_reset();
      end else begin
        reset = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
